// File: rtl/rob_commit_unit.sv
// rob_commit_unit
//   In-order retirement side of a circular reorder buffer. Tracks head,
//   tail and occupancy, waits for the head entry to complete, then either
//   offers its result to the register file (valid/ready) or raises a
//   one-cycle flush pulse when the head entry carries an exception.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   alloc_valid       allocator writes entry[tail] this cycle
//   entry_ready       per-entry completion bits
//   head_data         result of entry[head] (combinational read)
//   head_exception    exception flag of entry[head]
//   head, tail        current head / next allocation index
//   rob_full          occupancy == ROB_SIZE, or a flush is in progress
//   rob_empty         occupancy == 0
//   commit_valid/ready, commit_data, commit_idx   registered commit offer
//   flush_valid, flush_idx                        one-cycle flush pulse
//   commit_count      accepted-commit counter
//
// Build option
//   ROB_COMMIT_STATS_EN  when defined, commit_count counts accepted commits;
//                        otherwise it is tied to zero.
module rob_commit_unit #(
    parameter int ROB_SIZE       = 40,
    parameter int ROB_SIZE_WIDTH = 6,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_valid,
    input  logic [ROB_SIZE-1:0]       entry_ready,
    input  logic [DATA_WIDTH-1:0]     head_data,
    input  logic                      head_exception,
    output logic [ROB_SIZE_WIDTH-1:0] head,
    output logic [ROB_SIZE_WIDTH-1:0] tail,
    output logic                      rob_full,
    output logic                      rob_empty,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [DATA_WIDTH-1:0]     commit_data,
    output logic [ROB_SIZE_WIDTH-1:0] commit_idx,
    output logic                      flush_valid,
    output logic [ROB_SIZE_WIDTH-1:0] flush_idx,
    output logic [31:0]               commit_count
);

    localparam logic [ROB_SIZE_WIDTH:0]   COUNT_MAX = (ROB_SIZE_WIDTH+1)'(ROB_SIZE);
    localparam logic [ROB_SIZE_WIDTH:0]   COUNT_ONE = 1;
    localparam logic [ROB_SIZE_WIDTH-1:0] HEAD_LAST = ROB_SIZE_WIDTH'(ROB_SIZE - 1);
    localparam logic [ROB_SIZE_WIDTH-1:0] HEAD_ONE  = 1;

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

    state_t                    state, state_next;
    logic [ROB_SIZE_WIDTH:0]   count, count_next;
    logic [ROB_SIZE_WIDTH-1:0] head_next, head_inc;
    logic [ROB_SIZE_WIDTH:0]   tail_sum;
    logic                      commit_valid_next, flush_valid_next;
    logic [DATA_WIDTH-1:0]     commit_data_next;
    logic [ROB_SIZE_WIDTH-1:0] commit_idx_next, flush_idx_next;
    logic                      accept, alloc_take;

    // head + count fits in one extra bit because both are below 2^ROB_SIZE_WIDTH
    assign tail_sum  = {1'b0, head} + count;
    assign tail      = (tail_sum >= COUNT_MAX) ? ROB_SIZE_WIDTH'(tail_sum - COUNT_MAX)
                                               : ROB_SIZE_WIDTH'(tail_sum);
    assign head_inc  = (head == HEAD_LAST) ? '0 : head + HEAD_ONE;

    assign rob_empty = (count == '0);
    assign rob_full  = (count == COUNT_MAX) || (state == FLUSH);

    assign accept    = (state == COMMIT) && commit_ready;
    // A full ROB still takes an alloc when the head retires in the same
    // cycle: the slot being written is the one just freed.
    assign alloc_take = alloc_valid && (state != FLUSH) && ((count != COUNT_MAX) || accept);

    always_comb begin
        state_next        = state;
        head_next         = head;
        count_next        = count;
        commit_valid_next = commit_valid;
        commit_data_next  = commit_data;
        commit_idx_next   = commit_idx;
        flush_valid_next  = flush_valid;
        flush_idx_next    = flush_idx;

        if (alloc_take && !accept) begin
            count_next = count + COUNT_ONE;
        end else if (!alloc_take && accept) begin
            count_next = count - COUNT_ONE;
        end

        case (state)
            IDLE: begin
                if (!rob_empty && entry_ready[head]) begin
                    if (head_exception) begin
                        flush_valid_next = 1'b1;
                        flush_idx_next   = head;
                        state_next       = FLUSH;
                    end else begin
                        commit_valid_next = 1'b1;
                        commit_data_next  = head_data;
                        commit_idx_next   = head;
                        state_next        = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (commit_ready) begin
                    head_next         = head_inc;
                    commit_valid_next = 1'b0;
                    state_next        = IDLE;
                end
            end
            FLUSH: begin
                head_next        = tail;
                count_next       = '0;
                flush_valid_next = 1'b0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            head         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_data  <= '0;
            commit_idx   <= '0;
            flush_valid  <= 1'b0;
            flush_idx    <= '0;
        end else begin
            state        <= state_next;
            head         <= head_next;
            count        <= count_next;
            commit_valid <= commit_valid_next;
            commit_data  <= commit_data_next;
            commit_idx   <= commit_idx_next;
            flush_valid  <= flush_valid_next;
            flush_idx    <= flush_idx_next;
        end
    end

`ifdef ROB_COMMIT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
        end else if (accept) begin
            commit_count <= commit_count + 32'd1;
        end
    end
`else
    assign commit_count = '0;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

    localparam int ROB_SIZE = 40;
    localparam int RW       = 6;
    localparam int DW       = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                alloc_valid = 1'b0;
    logic [ROB_SIZE-1:0] entry_ready = '0;
    logic [DW-1:0]       head_data;
    logic                head_exception;
    logic [RW-1:0]       head, tail;
    logic                rob_full, rob_empty;
    logic                commit_valid;
    logic                commit_ready = 1'b0;
    logic [DW-1:0]       commit_data;
    logic [RW-1:0]       commit_idx;
    logic                flush_valid;
    logic [RW-1:0]       flush_idx;
    logic [31:0]         commit_count;

    // ROB storage as seen by the unit: indexed by its head output
    logic [DW-1:0] rob_data [64];
    logic          rob_exc  [64];
    assign head_data      = rob_data[head];
    assign head_exception = rob_exc[head];

    rob_commit_unit #(.ROB_SIZE(ROB_SIZE), .ROB_SIZE_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .entry_ready(entry_ready),
        .head_data(head_data), .head_exception(head_exception), .head(head), .tail(tail),
        .rob_full(rob_full), .rob_empty(rob_empty), .commit_valid(commit_valid),
        .commit_ready(commit_ready), .commit_data(commit_data), .commit_idx(commit_idx),
        .flush_valid(flush_valid), .flush_idx(flush_idx), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: occupancy, a pending offer, a pending flush
    int          m_head, m_count;
    bit          m_offer, m_flush;
    logic [DW-1:0] m_cdata;
    int          m_cidx, m_fidx;
    logic [31:0] m_commits;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_head <= 0; m_count <= 0; m_offer <= 0; m_flush <= 0;
            m_cdata <= '0; m_cidx <= 0; m_fidx <= 0; m_commits <= '0;
        end else begin : upd
            int h, c;
            bit acc, take;
            h = m_head;
            c = m_count;
            if (m_flush) begin
                m_head  <= (h + c) % ROB_SIZE;
                m_count <= 0;
                m_flush <= 0;
            end else begin
                acc  = m_offer && commit_ready;
                take = alloc_valid && (c < ROB_SIZE || acc);
                m_count <= c - int'(acc) + int'(take);
                if (acc) begin
                    m_offer   <= 0;
                    m_head    <= (h + 1) % ROB_SIZE;
                    m_commits <= m_commits + 32'd1;
                end else if (!m_offer && c > 0 && entry_ready[h]) begin
                    if (rob_exc[h]) begin
                        m_flush <= 1;
                        m_fidx  <= h;
                    end else begin
                        m_offer <= 1;
                        m_cdata <= rob_data[h];
                        m_cidx  <= h;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("head",         64'(head),         64'(m_head));
        chk("tail",         64'(tail),         64'((m_head + m_count) % ROB_SIZE));
        chk("rob_full",     64'(rob_full),     64'((m_count == ROB_SIZE) || m_flush));
        chk("rob_empty",    64'(rob_empty),    64'(m_count == 0));
        chk("commit_valid", 64'(commit_valid), 64'(m_offer));
        chk("commit_data",  64'(commit_data),  64'(m_cdata));
        chk("commit_idx",   64'(commit_idx),   64'(m_cidx));
        chk("flush_valid",  64'(flush_valid),  64'(m_flush));
        chk("flush_idx",    64'(flush_idx),    64'(m_fidx));
`ifdef ROB_COMMIT_STATS_EN
        chk("commit_count", 64'(commit_count), 64'(m_commits));
`else
        chk("commit_count", 64'(commit_count), 64'd0);
`endif
    end

    // Log of indices the register file actually accepted
    int acc_log[$];
    always @(posedge clk) begin
        if (!reset && commit_valid && commit_ready) acc_log.push_back(int'(commit_idx));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alloc_valid = 1'b0;
        commit_ready = 1'b0;
        entry_ready = '0;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rob_data[i] = $urandom;
            rob_exc[i]  = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        chk("rst_head",         64'(head),         64'd0);
        chk("rst_tail",         64'(tail),         64'd0);
        chk("rst_rob_empty",    64'(rob_empty),    64'd1);
        chk("rst_rob_full",     64'(rob_full),     64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_commit_count", 64'(commit_count), 64'd0);
        tick(2);
        reset = 1'b0;

        // Three allocs, all ready, ready held high
        entry_ready[2:0] = 3'b111;
        commit_ready = 1'b1;
        alloc_valid = 1'b1;
        tick(3);
        alloc_valid = 1'b0;
        tick(8);
        chk("s1_head",      64'(head),      64'd3);
        chk("s1_tail",      64'(tail),      64'd3);
        chk("s1_rob_empty", 64'(rob_empty), 64'd1);
        chk("s1_model_head", 64'(m_head),   64'd3);
        chk("s1_ncommits",  64'(acc_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++)
            chk("s1_commit_idx", 64'(acc_log[i]), 64'(i));

        // Offer held while commit_ready is low
        do_reset();
        entry_ready[0] = 1'b1;
        alloc_valid = 1'b1;
        tick(1);
        alloc_valid = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("s2_hold_valid", 64'(commit_valid), 64'd1);
            chk("s2_hold_data",  64'(commit_data),  64'(rob_data[0]));
            chk("s2_hold_head",  64'(head),         64'd0);
            tick(1);
        end
        commit_ready = 1'b1;
        tick(1);
        commit_ready = 1'b0;
        chk("s2_head_after", 64'(head),         64'd1);
        chk("s2_valid_after", 64'(commit_valid), 64'd0);

        // Fill to capacity, overfill, then commit with simultaneous alloc
        do_reset();
        alloc_valid = 1'b1;
        tick(39);
        chk("s3_tail39", 64'(tail), 64'd39);
        tick(1);
        chk("s3_full",      64'(rob_full), 64'd1);
        chk("s3_tail_wrap", 64'(tail),     64'd0);
        tick(1);
        chk("s3_full_over",  64'(rob_full), 64'd1);
        chk("s3_model_count", 64'(m_count), 64'd40);
        alloc_valid = 1'b0;
        entry_ready[0] = 1'b1;
        tick(1);
        chk("s3_offer", 64'(commit_valid), 64'd1);
        alloc_valid = 1'b1;
        commit_ready = 1'b1;
        tick(1);
        alloc_valid = 1'b0;
        commit_ready = 1'b0;
        entry_ready = '0;
        chk("s3_head",  64'(head),     64'd1);
        chk("s3_tail",  64'(tail),     64'd1);
        chk("s3_full2", 64'(rob_full), 64'd1);
        chk("s3_model_count2", 64'(m_count), 64'd40);

        // Flush from head 38 with five entries queued
        do_reset();
        entry_ready = '1;
        entry_ready[38] = 1'b0;
        rob_exc[38] = 1'b1;
        commit_ready = 1'b1;
        alloc_valid = 1'b1;
        tick(43);
        alloc_valid = 1'b0;
        tick(60);
        chk("s4_head38", 64'(head), 64'd38);
        chk("s4_tail3",  64'(tail), 64'd3);
        entry_ready[38] = 1'b1;
        tick(1);
        chk("s4_flush_valid", 64'(flush_valid), 64'd1);
        chk("s4_flush_idx",   64'(flush_idx),   64'd38);
        chk("s4_full_flush",  64'(rob_full),    64'd1);
        alloc_valid = 1'b1;   // must be ignored during the flush cycle
        tick(1);
        alloc_valid = 1'b0;
        entry_ready = '0;
        rob_exc[38] = 1'b0;
        chk("s4_flush_end", 64'(flush_valid), 64'd0);
        chk("s4_head",      64'(head),        64'd3);
        chk("s4_tail",      64'(tail),        64'd3);
        chk("s4_empty",     64'(rob_empty),   64'd1);
        chk("s4_not_full",  64'(rob_full),    64'd0);

        // Asynchronous reset in the middle of an offer
        do_reset();
        entry_ready[1:0] = 2'b11;
        alloc_valid = 1'b1;
        tick(2);
        alloc_valid = 1'b0;
        commit_ready = 1'b1;
        tick(1);
        commit_ready = 1'b0;
        tick(1);
        chk("s6_pre_valid", 64'(commit_valid), 64'd1);
        chk("s6_pre_idx",   64'(commit_idx),   64'd1);
        chk("s6_pre_head",  64'(head),         64'd1);
        #1 reset = 1'b1;
        #1;
        chk("s6_async_valid", 64'(commit_valid), 64'd0);
        chk("s6_async_head",  64'(head),         64'd0);
        chk("s6_async_idx",   64'(commit_idx),   64'd0);
        chk("s6_async_empty", 64'(rob_empty),    64'd1);
        tick(1);
        reset = 1'b0;
        entry_ready = '0;

        // Seven commits then one flush
        do_reset();
        entry_ready[7:0] = 8'hFF;
        rob_exc[7] = 1'b1;
        commit_ready = 1'b1;
        alloc_valid = 1'b1;
        tick(8);
        alloc_valid = 1'b0;
        tick(20);
        commit_ready = 1'b0;
        entry_ready = '0;
        rob_exc[7] = 1'b0;
        chk("s5_head",  64'(head),      64'd8);
        chk("s5_empty", 64'(rob_empty), 64'd1);
`ifdef ROB_COMMIT_STATS_EN
        chk("s5_commit_count", 64'(commit_count), 64'd7);
`else
        chk("s5_commit_count", 64'(commit_count), 64'd0);
`endif
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

In-order retirement side of the reorder buffer. It tracks head, tail and occupancy of a circular ROB of ROB_SIZE entries, checks the head entry's completion bit, and presents one committed result at a time to the register file over a valid/ready handshake. When the head entry carries an exception, it raises a single-cycle flush pulse. It sits between the ROB storage array (which it indexes by `head`) and the architectural register file and flush logic. The allocator uses the `tail` and `rob_full` outputs.

## Interface
- ROB_SIZE, 40, number of ROB entries; indices run 0..ROB_SIZE-1.
- ROB_SIZE_WIDTH, 6, width of the head/tail indices; ROB_SIZE <= 2^ROB_SIZE_WIDTH.
- DATA_WIDTH, 32, width of the result payload.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  allocator writes the entry at `tail` this cycle.
- entry_ready  in  ROB_SIZE  per-entry completion bits.
- head_data  in  DATA_WIDTH  result field of entry[head], read combinationally.
- head_exception  in  1  exception flag of entry[head].
- head  out  ROB_SIZE_WIDTH  current head index.
- tail  out  ROB_SIZE_WIDTH  next allocation index, equal to (head+count) mod ROB_SIZE.
- rob_full  out  1  count==ROB_SIZE; also forced high during FLUSH.
- rob_empty  out  1  count==0.
- commit_valid  out  1  registered commit offer.
- commit_ready  in  1  register file accepts the offer.
- commit_data  out  DATA_WIDTH  registered copy of head_data.
- commit_idx  out  ROB_SIZE_WIDTH  ROB index being committed.
- flush_valid  out  1  one-cycle flush pulse.
- flush_idx  out  ROB_SIZE_WIDTH  index of the faulting entry.
- commit_count  out  32  number of accepted commits (see Configuration).

## Operation
- State: `head` (ROB_SIZE_WIDTH bits), `count` (ROB_SIZE_WIDTH+1 bits), FSM state IDLE, COMMIT or FLUSH.
- IDLE
  - If !rob_empty, entry_ready[head] and !head_exception: latch commit_data<=head_data and commit_idx<=head, set commit_valid<=1, go to COMMIT.
  - If !rob_empty, entry_ready[head] and head_exception: set flush_valid<=1 and flush_idx<=head, go to FLUSH.
  - Otherwise stay in IDLE.
- COMMIT
  - commit_valid, commit_data and commit_idx hold stable until commit_ready is sampled high.
  - On acceptance: head<=head+1 with wrap from ROB_SIZE-1 to 0, count decrements, commit_valid<=0, go to IDLE.
- FLUSH
  - Lasts exactly one cycle, while flush_valid is high.
  - At the end of the cycle: head<=tail, count<=0, flush_valid<=0, go to IDLE.
  - alloc_valid is ignored in this cycle; rob_full is forced to 1 so the allocator stalls.
- Occupancy
  - alloc_valid increments count unless count==ROB_SIZE; an alloc while full is dropped and count saturates.
  - Alloc and commit acceptance in the same cycle leave count unchanged.
- Tail: computed as head+count, minus ROB_SIZE when the sum is >= ROB_SIZE.
- entry_ready[head] is sampled only in IDLE.

## Timing
- Reset values: head=0, tail=0, count=0, state=IDLE, commit_valid=0, commit_data=0, commit_idx=0, flush_valid=0, flush_idx=0, rob_empty=1, rob_full=0, commit_count=0.
- Latency from entry_ready[head] going high in IDLE to commit_valid going high: 1 cycle.
- Maximum throughput is one commit per 2 cycles (IDLE then COMMIT), because there is a single head read port.
- Exception to flush_valid: 1 cycle. A flush costs 2 cycles (IDLE then FLUSH) before the next entry can be examined.
- Reset asserted mid-COMMIT or mid-FLUSH:
  - All state returns to its reset value immediately and asynchronously.
  - A pending offer is lost with no acceptance, and no flush pulse completes.
- rob_full and rob_empty are combinational from count; tail is combinational from head and count.

## Configuration
- ROB_COMMIT_STATS_EN defined:
  - commit_count is a 32-bit register that increments on every accepted commit (commit_valid && commit_ready).
  - It wraps from 2^32-1 to 0 and is cleared by reset.
  - Flushes do not count.
- ROB_COMMIT_STATS_EN undefined: commit_count is tied to 0 and no counter is built.

## Test plan
- Reset, then 3 allocs at idx 0..2, set entry_ready[0..2], hold commit_ready=1 -> commit_idx 0,1,2 on alternating cycles; final head=3, tail=3, rob_empty=1.
- Entry 0 ready, commit_ready=0 for 5 cycles -> commit_valid and commit_data stay stable for all 5 cycles; head stays 0 until commit_ready=1, then head=1.
- Fill 40 entries, then 1 extra alloc -> rob_full=1 and count stays 40; commit 1 entry with a simultaneous alloc -> count stays 40, tail wraps from 39 to 0.
- Head=38 with 5 entries queued, entry 38 ready with exception -> flush_valid=1 for 1 cycle with flush_idx=38, then head=tail=3, count=0, rob_full=1 only during the FLUSH cycle.
- Assert reset during COMMIT with commit_valid=1 -> commit_valid=0 and head=0 in the same cycle, with no clock edge needed.
- With ROB_COMMIT_STATS_EN: 7 commits and 1 flush -> commit_count=7; without the macro, commit_count=0.
